// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I decode stage with output register and one-entry skid buffer; define DECODE_ILLEGAL_TRAP_EN to pass illegal instructions through flagged instead of as NOPs
module rv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_illegal
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            illegal;
  } dec_t;
  dec_t dec, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [3:0] f3_op;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic ok, accept;
  // funct3 to ALU op for the base (funct7 = 0) R/I-ALU encodings
  always_comb begin
    case (f3)
      3'b000:  f3_op = 4'd0;
      3'b001:  f3_op = 4'd2;
      3'b010:  f3_op = 4'd3;
      3'b011:  f3_op = 4'd4;
      3'b100:  f3_op = 4'd5;
      3'b101:  f3_op = 4'd6;
      3'b110:  f3_op = 4'd8;
      default: f3_op = 4'd9;
    endcase
  end
  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  // combinational decode of the incoming word, illegal encodings squashed before registration
  always_comb begin
    dec = '0;
    ok = 1'b1;
    dec.pc = in_pc;
    dec.rd = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.funct3 = f3;
    case (opc)
      7'b0110011: begin
        ok = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        dec.alu_op = f7 == 7'b0100000 ? (f3 == 3'b000 ? 4'd1 : 4'd7) : f3_op;
        dec.reg_write = 1'b1;
      end
      7'b0010011: begin
        ok = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
        dec.alu_op = (f3 == 3'b101 && f7 == 7'b0100000) ? 4'd7 : f3_op;
        dec.alu_src_imm = 1'b1;
        dec.imm = f3[1:0] == 2'b01 ? {27'b0, in_instr[24:20]} : imm_i;
        dec.reg_write = 1'b1;
      end
      7'b0000011: begin
        ok = !(f3 == 3'b011 || f3[2:1] == 2'b11);
        dec.alu_src_imm = 1'b1;
        dec.imm = imm_i;
        dec.mem_read = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b0100011: begin
        ok = f3 < 3'd3;
        dec.alu_src_imm = 1'b1;
        dec.imm = imm_s;
        dec.mem_write = 1'b1;
      end
      7'b1100011: begin
        ok = f3[2:1] != 2'b01;
        dec.alu_op = 4'd1;
        dec.imm = imm_b;
        dec.branch = 1'b1;
      end
      7'b1101111: begin
        dec.imm = imm_j;
        dec.jal = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b1100111: begin
        ok = f3 == 3'b000;
        dec.alu_src_imm = 1'b1;
        dec.imm = imm_i;
        dec.jalr = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b0110111: begin
        dec.alu_op = 4'd10;
        dec.alu_src_imm = 1'b1;
        dec.imm = imm_u;
        dec.reg_write = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    if (!ok) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      dec.imm = '0;
      dec.alu_op = 4'd0;
      {dec.alu_src_imm, dec.reg_write, dec.mem_read, dec.mem_write, dec.branch, dec.jal, dec.jalr} = '0;
      dec.illegal = 1'b1;
`else
      dec = '0;
      dec.pc = in_pc;
      dec.alu_src_imm = 1'b1;
`endif
    end
  end
  assign in_ready = !skid_valid_q;
  assign accept = in_valid && in_ready;
  // output register refills from skid first, otherwise from the input; stalled accepts park in skid
  always_comb begin
    out_d = out_q;
    out_valid_d = out_valid_q;
    skid_d = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      out_valid_d = skid_valid_q || accept;
      out_d = skid_valid_q ? skid_q : accept ? dec : out_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_d = dec;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      out_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end
  // pipeline state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
  assign out_valid       = out_valid_q;
  assign out_pc          = out_q.pc;
  assign out_rd          = out_q.rd;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_imm         = out_q.imm;
  assign out_funct3      = out_q.funct3;
  assign out_alu_op      = out_q.alu_op;
  assign out_alu_src_imm = out_q.alu_src_imm;
  assign out_reg_write   = out_q.reg_write;
  assign out_mem_read    = out_q.mem_read;
  assign out_mem_write   = out_q.mem_write;
  assign out_branch      = out_q.branch;
  assign out_jal         = out_q.jal;
  assign out_jalr        = out_q.jalr;
  assign out_illegal     = out_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed and random checks of rv_decode_stage against a queue-based decode model
module tb_rv_decode_stage;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_funct3;
  logic [3:0] out_alu_op;
  logic out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_illegal;
  int cmp = 0;
  int mis = 0;
  bit acc;
  always #5 clk = ~clk;
  rv_decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr), .out_illegal(out_illegal)
  );
  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [3:0] op;
    logic src, rw, mr, mw, br, jal, jalr, ill;
    bit chk_f, chk_imm, chk_src;
  } exp_t;
  exp_t q[$];
  function automatic exp_t model(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    bit legal;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] rop [8];
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    rop = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f7 = i[31:25];
    f3 = i[14:12];
    i12 = i[31:20];
    s12 = {i[31:25], i[11:7]};
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '{default: 0};
    e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3;
    e.chk_f = 1; e.chk_imm = 1; e.chk_src = 1;
    legal = 1;
    case (i[6:0])
      7'h33: begin legal = f7 == 0 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
        e.op = f7 == 7'h20 ? (f3 == 0 ? 4'd1 : 4'd7) : rop[f3]; e.rw = 1; e.chk_imm = 0; end
      7'h13: begin legal = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        e.op = (f3 == 5 && f7 == 7'h20) ? 4'd7 : rop[f3]; e.src = 1; e.rw = 1;
        e.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : 32'(i12); end
      7'h03: begin legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.src = 1; e.imm = 32'(i12); e.mr = 1; e.rw = 1; end
      7'h23: begin legal = f3 inside {3'd0, 3'd1, 3'd2}; e.src = 1; e.imm = 32'(s12); e.mw = 1; end
      7'h63: begin legal = !(f3 inside {3'd2, 3'd3}); e.op = 4'd1; e.imm = 32'(b13); e.br = 1; end
      7'h6F: begin e.imm = 32'(j21); e.jal = 1; e.rw = 1; e.chk_src = 0; end
      7'h67: begin legal = f3 == 0; e.src = 1; e.imm = 32'(i12); e.jalr = 1; e.rw = 1; end
      7'h37: begin e.op = 4'd10; e.src = 1; e.imm = {i[31:12], 12'b0}; e.rw = 1; end
      default: legal = 0;
    endcase
    if (e.rd == 0) e.rw = 0;
    if (!legal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.ill = 1; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jal = 0; e.jalr = 0;
      e.chk_f = 0; e.chk_imm = 0; e.chk_src = 0;
`else
      e = '{default: 0};
      e.pc = pc; e.src = 1; e.chk_f = 1; e.chk_imm = 1; e.chk_src = 1;
`endif
    end
    return e;
  endfunction
  function automatic logic [31:0] gen();
    logic [6:0] ops [8];
    logic [31:0] w;
    int r, s;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    w = $urandom;
    r = $urandom_range(0, 15);
    s = $urandom_range(0, 3);
    if (r < 14) w[6:0] = ops[r % 8];
    if (s == 0) w[31:25] = 7'h00;
    if (s == 1) w[31:25] = 7'h20;
    return w;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("pc", out_pc, q[0].pc);
      if (q[0].chk_f) begin
        chk("rd", out_rd, q[0].rd);
        chk("rs1", out_rs1, q[0].rs1);
        chk("rs2", out_rs2, q[0].rs2);
        chk("funct3", out_funct3, q[0].f3);
        chk("alu_op", out_alu_op, q[0].op);
      end
      if (q[0].chk_imm) chk("imm", out_imm, q[0].imm);
      if (q[0].chk_src) chk("alu_src_imm", out_alu_src_imm, q[0].src);
      chk("reg_write", out_reg_write, q[0].rw);
      chk("mem_read", out_mem_read, q[0].mr);
      chk("mem_write", out_mem_write, q[0].mw);
      chk("branch", out_branch, q[0].br);
      chk("jal", out_jal, q[0].jal);
      chk("jalr", out_jalr, q[0].jalr);
      chk("illegal", out_illegal, q[0].ill);
    end
  endtask
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    acc = in_valid && q.size() < 2 && !flush && !reset;
    if (reset || flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(model(in_instr, in_pc));
    end
    #1;
  endtask
  task automatic send(logic [31:0] instr, logic [31:0] pc);
    in_instr = instr;
    in_pc = pc;
    step();
  endtask
  initial begin
    int n, cyc;
    logic [31:0] cur, pcv;
    reset = 1; flush = 0; in_valid = 0; out_ready = 1; in_instr = 0; in_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 0;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.pc", out_pc, 0);
    chk("rst.imm", out_imm, 0);
    chk("rst.rd", out_rd, 0);
    chk("rst.reg_write", out_reg_write, 0);
    in_valid = 1;
    send(32'h002081B3, 32'h100);
    chk("add.valid", out_valid, 1);
    chk("add.rd", out_rd, 3); chk("add.rs1", out_rs1, 1); chk("add.rs2", out_rs2, 2);
    chk("add.op", out_alu_op, 0); chk("add.rw", out_reg_write, 1); chk("add.src", out_alu_src_imm, 0);
    send(32'hFFF00293, 32'h104);
    chk("addi.imm", out_imm, 32'hFFFFFFFF); chk("addi.op", out_alu_op, 0);
    send(32'h40325213, 32'h108);
    chk("srai.op", out_alu_op, 7); chk("srai.imm", out_imm, 3);
    chk("srai.rs1", out_rs1, 4); chk("srai.rd", out_rd, 4);
    send(32'h403100B3, 32'h10C);
    chk("sub.op", out_alu_op, 1);
    send(32'h123453B7, 32'h110);
    chk("lui.op", out_alu_op, 10); chk("lui.imm", out_imm, 32'h12345000); chk("lui.rd", out_rd, 7);
    in_valid = 0;
    repeat (2) step();
    n = 0; cyc = 0; in_valid = 1;
    while (n < 6 && cyc < 50) begin
      in_instr = ((n + 1) << 20) | ((n + 1) << 7) | 32'h13;
      in_pc = 32'h200 + 4 * n;
      out_ready = !(cyc inside {2, 3, 4});
      step();
      if (acc) n++;
      cyc++;
    end
    chk("stream.sent", n, 6);
    chk("stream.cycles", cyc, 9);
    in_valid = 0; out_ready = 1;
    repeat (4) step();
    chk("stream.drained", out_valid, 0);
    out_ready = 0; in_valid = 1;
    send(32'h00500093, 32'h300);
    send(32'h00600113, 32'h304);
    chk("fill.in_ready", in_ready, 0);
    in_instr = 32'h00700193; in_pc = 32'h308; flush = 1;
    step();
    flush = 0;
    chk("flush.out_valid", out_valid, 0);
    chk("flush.in_ready", in_ready, 1);
    in_valid = 0; out_ready = 1;
    repeat (3) step();
    chk("flush.gone", out_valid, 0);
    in_valid = 1;
    send(32'h00000000, 32'h400);
    in_valid = 0;
    chk("ill.pc", out_pc, 32'h400);
    chk("ill.rw", out_reg_write, 0);
    chk("ill.mr", out_mem_read, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill.flag", out_illegal, 1);
`else
    chk("ill.flag", out_illegal, 0);
    chk("ill.op", out_alu_op, 0);
    chk("ill.src", out_alu_src_imm, 1);
    chk("ill.imm", out_imm, 0);
    chk("ill.rd", out_rd, 0);
`endif
    step();
    cur = gen(); pcv = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 49) == 0;
      reset = $urandom_range(0, 199) == 0;
      in_instr = cur; in_pc = pcv;
      step();
      if (acc || flush || reset || !in_valid) begin
        cur = gen();
        pcv += 4;
      end
    end
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
